// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e      : controller FSM state encoding (exposed on state_dbg)
//   LW_RUN       : load enables with every front-end register loading
//   LW_HOLD      : load enables with every front-end register frozen
//   REG_ZERO     : architectural $zero, never a real dependency
//   load_use_hit : load-use dependency between ID/EX load and IF/ID consumer
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLoadUse = 2'd1,
    StFlush   = 2'd2,
    StFreeze  = 2'd3
  } state_e;

  localparam logic [2:0] LW_RUN   = 3'b111;
  localparam logic [2:0] LW_HOLD  = 3'b000;
  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt,
                                        input logic       id_uses_rt);
    return mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears the count
//   inc   : add one this cycle (ignored once the count is all-ones)
//   count : current count
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// Front-end hazard controller: load-use stalls, redirect flushes and
// instruction-memory freezes, plus stall/flush performance counters.
//   clk, rst          : clock, synchronous active-high reset
//   id_rs, id_rt      : source fields of the IF/ID instruction
//   id_uses_rt        : IF/ID instruction reads rt
//   ex_mem_read, ex_rt: ID/EX load and its destination
//   redirect          : taken branch/jump resolved this cycle
//   mem_busy          : instruction memory not ready
//   lw_hazard         : load enables {IF/ID instr, IF/ID pc, PC}, 1 = load
//   clear_ifid        : clear both IF/ID registers
//   bubble_idex       : insert NOP into ID/EX
//   state_dbg         : current FSM state
//   stall_count       : cycles with any front-end load enable low
//   flush_count       : cycles with clear_ifid asserted
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             redirect,
  input  logic             mem_busy,
  output logic [2:0]       lw_hazard,
  output logic             clear_ifid,
  output logic             bubble_idex,
  output logic [1:0]       state_dbg,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Clear cycles still owed after the redirect cycle itself.
  localparam logic [1:0] FlushReload = 2'(FLUSH_CYCLES - 1);

  state_e     r_state;
  state_e     w_state_next;
  logic [1:0] r_remaining;
  logic [1:0] w_remaining_next;
  logic       w_hit;
  logic       w_stall_inc;
  logic       w_flush_inc;

  assign w_hit = load_use_hit(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StRun;
      r_remaining <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    if (redirect) begin
      if (FLUSH_CYCLES > 1) begin
        w_state_next     = StFlush;
        w_remaining_next = FlushReload;
      end else begin
        w_state_next     = StRun;
        w_remaining_next = 2'd0;
      end
    end else begin
      unique case (r_state)
        StFlush: begin
          // Memory stalls are not honoured until the flush has drained.
          w_remaining_next = r_remaining - 2'd1;
          w_state_next     = (r_remaining == 2'd1) ? StRun : StFlush;
        end
        StLoadUse: begin
          // Detection suppressed: the one-cycle stall already resolved it.
          w_state_next = mem_busy ? StFreeze : StRun;
        end
        StRun, StFreeze: begin
          // A freeze releases straight into normal run behaviour, so a
          // dependency still present when memory returns stalls at once.
          if (mem_busy)   w_state_next = StFreeze;
          else if (w_hit) w_state_next = StLoadUse;
          else            w_state_next = StRun;
        end
        default: w_state_next = StRun;
      endcase
    end
  end

  // Output logic
  always_comb begin
    lw_hazard   = LW_RUN;
    clear_ifid  = 1'b0;
    bubble_idex = 1'b0;
    if (rst) begin
      // Benign outputs while held in reset.
    end else if (redirect) begin
      clear_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else begin
      unique case (r_state)
        StFlush: clear_ifid = 1'b1;
        StLoadUse: begin
          if (mem_busy) begin
            lw_hazard   = LW_HOLD;
            bubble_idex = 1'b1;
          end
        end
        StRun, StFreeze: begin
          if (mem_busy || w_hit) begin
            lw_hazard   = LW_HOLD;
            bubble_idex = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_dbg   = r_state;
  assign w_stall_inc = (lw_hazard != LW_RUN);
  assign w_flush_inc = clear_ifid;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_stall_inc),
    .count(stall_count)
  );

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_flush_inc),
    .count(flush_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, redirect, mem_busy;

  logic [2:0] lw_hazard;
  logic       clear_ifid, bubble_idex;
  logic [1:0] state_dbg;
  logic [3:0] stall_count, flush_count;

  logic [2:0]  lw_hazard1;
  logic        clear_ifid1, bubble_idex1;
  logic [1:0]  state_dbg1;
  logic [15:0] stall_count1, flush_count1;

  int n_vec = 0;
  int n_err = 0;

  hazard_controller #(.FLUSH_CYCLES(3), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .redirect(redirect), .mem_busy(mem_busy),
    .lw_hazard(lw_hazard), .clear_ifid(clear_ifid), .bubble_idex(bubble_idex),
    .state_dbg(state_dbg), .stall_count(stall_count), .flush_count(flush_count)
  );

  // Default-parameter instance sharing the same stimulus.
  hazard_controller u_dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .redirect(redirect), .mem_busy(mem_busy),
    .lw_hazard(lw_hazard1), .clear_ifid(clear_ifid1), .bubble_idex(bubble_idex1),
    .state_dbg(state_dbg1), .stall_count(stall_count1), .flush_count(flush_count1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs and let combinational outputs settle, well before the next edge.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                       input logic mr, input logic [4:0] ert, input logic rd,
                       input logic mb);
    id_rs = rs; id_rt = rt; id_uses_rt = ut; ex_mem_read = mr; ex_rt = ert;
    redirect = rd; mem_busy = mb;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(8, 8, 1, 1, 8, 1, 1);
    n_vec++; if (lw_hazard !== 3'b111) begin n_err++; $display("FAIL rst_lw got %b want 111", lw_hazard); end
    n_vec++; if (clear_ifid !== 1'b0) begin n_err++; $display("FAIL rst_clear got %b want 0", clear_ifid); end
    n_vec++; if (bubble_idex !== 1'b0) begin n_err++; $display("FAIL rst_bubble got %b want 0", bubble_idex); end
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", state_dbg); end
    n_vec++; if (stall_count !== 4'd0) begin n_err++; $display("FAIL rst_stall got %0d want 0", stall_count); end
    n_vec++; if (flush_count !== 4'd0) begin n_err++; $display("FAIL rst_flush got %0d want 0", flush_count); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(8, 0, 0, 1, 8, 0, 0);
    n_vec++; if (lw_hazard !== 3'b000) begin n_err++; $display("FAIL lu_lw got %b want 000", lw_hazard); end
    n_vec++; if (bubble_idex !== 1'b1) begin n_err++; $display("FAIL lu_bubble got %b want 1", bubble_idex); end
    n_vec++; if (clear_ifid !== 1'b0) begin n_err++; $display("FAIL lu_clear got %b want 0", clear_ifid); end
    tick();
    n_vec++; if (state_dbg !== 2'd1) begin n_err++; $display("FAIL lu_state got %0d want 1", state_dbg); end
    n_vec++; if (lw_hazard !== 3'b111) begin n_err++; $display("FAIL lu_release got %b want 111", lw_hazard); end
    n_vec++; if (bubble_idex !== 1'b0) begin n_err++; $display("FAIL lu_nobubble got %b want 0", bubble_idex); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL lu_back got %0d want 0", state_dbg); end
    n_vec++; if (stall_count !== 4'd1) begin n_err++; $display("FAIL lu_count got %0d want 1", stall_count); end
  endtask

  task automatic test_no_stall();
    do_reset();
    drive(0, 0, 0, 1, 0, 0, 0);  // $zero destination
    n_vec++; if (lw_hazard !== 3'b111) begin n_err++; $display("FAIL zero_lw got %b want 111", lw_hazard); end
    tick();
    drive(3, 8, 0, 1, 8, 0, 0);  // rt match but rt not read
    n_vec++; if (lw_hazard !== 3'b111) begin n_err++; $display("FAIL nort_lw got %b want 111", lw_hazard); end
    tick();
    n_vec++; if (stall_count !== 4'd0) begin n_err++; $display("FAIL nostall_count got %0d want 0", stall_count); end
    drive(3, 8, 1, 1, 8, 0, 0);  // same but rt is read
    n_vec++; if (lw_hazard !== 3'b000) begin n_err++; $display("FAIL rt_lw got %b want 000", lw_hazard); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flush();
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0);
    n_vec++; if (clear_ifid !== 1'b1) begin n_err++; $display("FAIL fl0_clear got %b want 1", clear_ifid); end
    n_vec++; if (bubble_idex !== 1'b1) begin n_err++; $display("FAIL fl0_bubble got %b want 1", bubble_idex); end
    n_vec++; if (lw_hazard !== 3'b111) begin n_err++; $display("FAIL fl0_lw got %b want 111", lw_hazard); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (state_dbg !== 2'd2) begin n_err++; $display("FAIL fl1_state got %0d want 2", state_dbg); end
    n_vec++; if (clear_ifid !== 1'b1) begin n_err++; $display("FAIL fl1_clear got %b want 1", clear_ifid); end
    n_vec++; if (bubble_idex !== 1'b0) begin n_err++; $display("FAIL fl1_bubble got %b want 0", bubble_idex); end
    n_vec++; if (clear_ifid1 !== 1'b0) begin n_err++; $display("FAIL fc1_clear got %b want 0", clear_ifid1); end
    tick();
    drive(8, 0, 0, 1, 8, 0, 1);  // busy and hit ignored during flush
    n_vec++; if (clear_ifid !== 1'b1) begin n_err++; $display("FAIL fl2_clear got %b want 1", clear_ifid); end
    n_vec++; if (lw_hazard !== 3'b111) begin n_err++; $display("FAIL fl2_lw got %b want 111", lw_hazard); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (clear_ifid !== 1'b0) begin n_err++; $display("FAIL fl3_clear got %b want 0", clear_ifid); end
    n_vec++; if (flush_count !== 4'd3) begin n_err++; $display("FAIL fl_count got %0d want 3", flush_count); end
    n_vec++; if (flush_count1 !== 16'd1) begin n_err++; $display("FAIL fc1_count got %0d want 1", flush_count1); end
    // Second redirect two cycles in restarts the three-cycle window.
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    n_vec++; if (bubble_idex !== 1'b1) begin n_err++; $display("FAIL re_bubble got %b want 1", bubble_idex); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (clear_ifid !== 1'b1) begin n_err++; $display("FAIL re_clear got %b want 1", clear_ifid); end
    tick();
    n_vec++; if (clear_ifid !== 1'b0) begin n_err++; $display("FAIL re_done got %b want 0", clear_ifid); end
    n_vec++; if (flush_count !== 4'd5) begin n_err++; $display("FAIL re_count got %0d want 5", flush_count); end
  endtask

  task automatic test_freeze();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(8, 0, 0, 1, 8, 0, 1);
      n_vec++; if (lw_hazard !== 3'b000) begin n_err++; $display("FAIL fz_lw[%0d] got %b want 000", i, lw_hazard); end
      n_vec++; if (bubble_idex !== 1'b1) begin n_err++; $display("FAIL fz_bubble[%0d] got %b want 1", i, bubble_idex); end
      tick();
    end
    n_vec++; if (state_dbg !== 2'd3) begin n_err++; $display("FAIL fz_state got %0d want 3", state_dbg); end
    drive(8, 0, 0, 1, 8, 0, 0);  // memory back, dependency still there
    n_vec++; if (lw_hazard !== 3'b000) begin n_err++; $display("FAIL fzhit_lw got %b want 000", lw_hazard); end
    tick();
    n_vec++; if (state_dbg !== 2'd1) begin n_err++; $display("FAIL fzhit_state got %0d want 1", state_dbg); end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (stall_count !== 4'd5) begin n_err++; $display("FAIL fzhit_count got %0d want 5", stall_count); end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(8, 0, 0, 1, 8, 0, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (lw_hazard !== 3'b111) begin n_err++; $display("FAIL fzend_lw got %b want 111", lw_hazard); end
    tick();
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL fzend_state got %0d want 0", state_dbg); end
    n_vec++; if (stall_count !== 4'd4) begin n_err++; $display("FAIL fzend_count got %0d want 4", stall_count); end
  endtask

  task automatic test_priority();
    do_reset();
    drive(8, 0, 0, 1, 8, 1, 1);
    n_vec++; if (lw_hazard !== 3'b111) begin n_err++; $display("FAIL pri_lw got %b want 111", lw_hazard); end
    n_vec++; if (clear_ifid !== 1'b1) begin n_err++; $display("FAIL pri_clear got %b want 1", clear_ifid); end
    tick();
    n_vec++; if (state_dbg !== 2'd2) begin n_err++; $display("FAIL pri_state got %0d want 2", state_dbg); end
    // Reset in the middle of a freeze.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_vec++; if (lw_hazard !== 3'b111) begin n_err++; $display("FAIL rstfz_lw got %b want 111", lw_hazard); end
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rstfz_state got %0d want 0", state_dbg); end
    n_vec++; if (stall_count !== 4'd0) begin n_err++; $display("FAIL rstfz_count got %0d want 0", stall_count); end
    n_vec++; if (lw_hazard !== 3'b111) begin n_err++; $display("FAIL rstfz_after got %b want 111", lw_hazard); end
    // Reset in the middle of a flush.
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (clear_ifid !== 1'b0) begin n_err++; $display("FAIL rstfl_during got %b want 0", clear_ifid); end
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (clear_ifid !== 1'b0) begin n_err++; $display("FAIL rstfl_after got %b want 0", clear_ifid); end
    n_vec++; if (flush_count !== 4'd0) begin n_err++; $display("FAIL rstfl_count got %0d want 0", flush_count); end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (20) tick();
    n_vec++; if (stall_count !== 4'd15) begin n_err++; $display("FAIL sat_count got %0d want 15", stall_count); end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (stall_count !== 4'd15) begin n_err++; $display("FAIL sat_hold got %0d want 15", stall_count); end
    n_vec++; if (stall_count1 !== 16'd20) begin n_err++; $display("FAIL wide_count got %0d want 20", stall_count1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    test_reset();
    test_load_use();
    test_no_stall();
    test_flush();
    test_freeze();
    test_priority();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, range 1..4: consecutive cycles clear_ifid is held per redirect.
REQ-002 Parameter CNT_W, default 16: width of each performance counter.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 id_rs  input  5  rs field of instruction in IF/ID.
REQ-007 id_rt  input  5  rt field of instruction in IF/ID.
REQ-008 id_uses_rt  input  1  IF/ID instruction reads rt.
REQ-009 ex_mem_read  input  1  ID/EX instruction is a load.
REQ-010 ex_rt  input  5  destination rt of ID/EX load.
REQ-011 redirect  input  1  taken branch/jump resolved this cycle; PC input already carries target.
REQ-012 mem_busy  input  1  instruction memory not ready; front end must freeze.
REQ-013 lw_hazard  output  3  load enables: bit2 IF/ID instr reg, bit1 IF/ID pc reg, bit0 PC reg; 1 = load.
REQ-014 clear_ifid  output  1  synchronous clear of both IF/ID registers.
REQ-015 bubble_idex  output  1  insert NOP into ID/EX this cycle.
REQ-016 state_dbg  output  2  current FSM state encoding.
REQ-017 stall_count  output  CNT_W  cycles with lw_hazard != 3'b111.
REQ-018 flush_count  output  CNT_W  cycles with clear_ifid = 1.

Function
REQ-019 States SHALL be RUN, LOADUSE, FLUSH, FREEZE; outputs are combinational from state and inputs, state/counters registered.
REQ-020 Load-use hit SHALL be ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)).
REQ-021 Per-cycle priority SHALL be: rst > redirect > mem_busy > load-use hit > normal run.
REQ-022 Redirect (any state): lw_hazard=111, clear_ifid=1, bubble_idex=1; if FLUSH_CYCLES>1 next state FLUSH with remaining = FLUSH_CYCLES-1, else RUN.
REQ-023 FLUSH: lw_hazard=111, clear_ifid=1, bubble_idex=0; decrement remaining; exit to RUN when remaining reaches 0; new redirect reloads remaining; mem_busy ignored until exit.
REQ-024 mem_busy (not redirect) in RUN/LOADUSE/FREEZE: lw_hazard=000, clear_ifid=0, bubble_idex=1; state FREEZE; leave to RUN on first cycle mem_busy=0.
REQ-025 Load-use hit in RUN: lw_hazard=000, bubble_idex=1, clear_ifid=0; next state LOADUSE.
REQ-026 LOADUSE: lw_hazard=111, no bubble, detection suppressed; next state RUN (stall is exactly 1 cycle per load).
REQ-027 RUN, no event: lw_hazard=111, clear_ifid=0, bubble_idex=0.
REQ-028 Counters SHALL increment by 1 on qualifying cycles and saturate at all-ones without wrap.
REQ-029 Register $zero (ex_rt=0) SHALL never cause a stall.

Reset
REQ-030 While rst=1 at a clock edge: state RUN, remaining 0, both counters 0.
REQ-031 During cycles with rst=1, outputs SHALL be lw_hazard=111, clear_ifid=0, bubble_idex=0, regardless of inputs.
REQ-032 Reset mid-FLUSH/FREEZE SHALL abandon the operation; no clear or stall after rst deasserts unless re-triggered.

Structure
REQ-033 Package hazard_pkg SHALL hold state encoding (RUN=0, LOADUSE=1, FLUSH=2, FREEZE=3), LW_RUN=3'b111, LW_HOLD=3'b000, REG_ZERO=5'd0.
REQ-034 Sub-module sat_counter (width CNT_W, sync reset, inc, saturate) SHALL be instantiated twice.

Verification
REQ-035 ex_mem_read=1, ex_rt=8, id_rs=8 in RUN -> one cycle lw_hazard=000, bubble_idex=1, then 111; stall_count=1.
REQ-036 Same as 035 but ex_rt=0 or id_uses_rt=0 with id_rt=8, id_rs=3 -> no stall, stall_count=0.
REQ-037 FLUSH_CYCLES=3, redirect one cycle -> clear_ifid=1 for 3 cycles, bubble only first, flush_count=3; second redirect in cycle 2 -> 3 more from there.
REQ-038 mem_busy high 4 cycles with simultaneous load-use hit -> lw_hazard=000 for 4 cycles, then LOADUSE not entered unless hit still present; stall_count=4 (+1 if hit).
REQ-039 redirect and mem_busy and hit same cycle -> redirect behaviour only; rst during FREEZE -> next cycle lw_hazard=111, counters 0.
REQ-040 CNT_W=4, 20 stall cycles -> stall_count holds 15.
